// File: rtl/ram_arbiter.sv
// Two-requester arbiter (CPU core, program loader) for the shared single-port RAM.
// Optional per-requester grant counters are built only when ARB_CNT_EN is defined.
module ram_arbiter #(
  parameter int AW          = 4,
  parameter int DW          = 8,
  parameter int LOADER_PRIO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_mode,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef ARB_CNT_EN
  ,
  input  logic          cnt_clr,
  output logic [7:0]    cpu_cnt,
  output logic [7:0]    ldr_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;

  localparam logic PRIO_FIXED = (LOADER_PRIO != 0);

  logic [1:0]    state_q, state_d;
  logic          win_ldr_q, win_ldr_d;
  logic          last_ldr_q, last_ldr_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          ldr_gnt_q, ldr_gnt_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic          ldr_rvalid_q, ldr_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;

  logic cpu_elig;
  logic pick_ldr;

  assign cpu_elig = cpu_req & ~prog_mode;
  // Loader wins outright, or on a tie when fixed priority or the CPU was served last.
  assign pick_ldr = ldr_req & (~cpu_elig | PRIO_FIXED | ~last_ldr_q);

  always_comb begin
    state_d      = state_q;
    win_ldr_d    = win_ldr_q;
    last_ldr_d   = last_ldr_q;
    cpu_gnt_d    = 1'b0;
    ldr_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_elig || ldr_req) begin
          state_d     = ACCESS;
          win_ldr_d   = pick_ldr;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_ldr ? ldr_we    : cpu_we;
          mem_addr_d  = pick_ldr ? ldr_addr  : cpu_addr;
          mem_wdata_d = pick_ldr ? ldr_wdata : cpu_wdata;
          cpu_gnt_d   = ~pick_ldr;
          ldr_gnt_d   = pick_ldr;
        end
      end
      ACCESS: begin
        last_ldr_d = win_ldr_q;
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d      = RDATA;
          cpu_rvalid_d = ~win_ldr_q;
          ldr_rvalid_d = win_ldr_q;
        end
      end
      RDATA: begin
        state_d = IDLE;
        if (win_ldr_q) ldr_rdata_d = mem_rdata;
        else           cpu_rdata_d = mem_rdata;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      win_ldr_q    <= 1'b0;
      last_ldr_q   <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_ldr_q    <= win_ldr_d;
      last_ldr_q   <= last_ldr_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign ldr_gnt    = ldr_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

  // The RAM output register is forwarded during the rvalid cycle; the local copy holds it afterwards.
  assign cpu_rdata = cpu_rvalid_q ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata = ldr_rvalid_q ? mem_rdata : ldr_rdata_q;

`ifdef ARB_CNT_EN
  logic [7:0] cpu_cnt_q, cpu_cnt_d;
  logic [7:0] ldr_cnt_q, ldr_cnt_d;

  always_comb begin
    cpu_cnt_d = cpu_cnt_q;
    ldr_cnt_d = ldr_cnt_q;
    if (cnt_clr) begin
      cpu_cnt_d = '0;
      ldr_cnt_d = '0;
    end else begin
      if (cpu_gnt_q && (cpu_cnt_q != 8'hFF)) cpu_cnt_d = cpu_cnt_q + 8'd1;
      if (ldr_gnt_q && (ldr_cnt_q != 8'hFF)) ldr_cnt_d = ldr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_cnt_q <= '0;
      ldr_cnt_q <= '0;
    end else begin
      cpu_cnt_q <= cpu_cnt_d;
      ldr_cnt_q <= ldr_cnt_d;
    end
  end

  assign cpu_cnt = cpu_cnt_q;
  assign ldr_cnt = ldr_cnt_q;
`endif

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 16x8 program/data RAM between two requesters: the CPU core (fetch/operand/store path) and the byte loader that writes programs in prog mode.
- Registered request/grant handshake with a fixed 1-cycle RAM read latency.
- Arbitration is configurable: fixed loader priority or round-robin.
- Sits between the RAM macro and the CPU and loader blocks.

Parameters:
- AW, 4, RAM address width.
- DW, 8, RAM data width.
- LOADER_PRIO, 1:
  - 1: the loader wins every tie.
  - 0: round-robin, where the requester not granted last wins a tie.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- prog_mode  in  1  1: CPU requests masked; 0: both requesters eligible
- cpu_req  in  1  CPU access request; held high until cpu_gnt
- cpu_we  in  1  1: write, 0: read; sampled with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  1-cycle pulse: CPU access issued this cycle
- cpu_rvalid  out  1  1-cycle pulse: cpu_rdata valid
- cpu_rdata  out  DW  read data; holds last value between reads
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/AW/DW  loader request, same semantics as the CPU inputs
- ldr_gnt, ldr_rvalid, ldr_rdata  out  1/1/DW  loader grant and read return
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid the cycle after mem_en with mem_we=0
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (rst=0, async):
  - State goes to IDLE.
  - All outputs go to 0, including cpu_rdata and ldr_rdata.
  - last_grant resets to CPU, so the first round-robin tie goes to the loader.
  - Reset mid-access aborts the access; no rvalid is produced afterwards.
- States: IDLE, ACCESS, RDATA.
- IDLE:
  - Eligible requesters are ldr_req, plus cpu_req only when prog_mode=0.
  - With no eligible requester, stay in IDLE.
  - Otherwise select the winner per LOADER_PRIO / last_grant and go to ACCESS.
  - Latch the winner, we, addr and wdata.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched request.
  - The winner's gnt=1 and last_grant updates to the winner.
  - Write: return to IDLE. Read: go to RDATA.
- RDATA (exactly 1 cycle):
  - mem_en=0.
  - The winner's rvalid=1 and its rdata is loaded from mem_rdata.
  - Return to IDLE.
- Timing:
  - Request seen in cycle N gives gnt in N+1 and, for a read, rvalid in N+2.
  - Write throughput: 1 per 2 cycles. Read throughput: 1 per 3 cycles.
- Requesters must drop req in the cycle after gnt.
  - If req is still high in IDLE, it is treated as a new request.
- The losing requester is unaffected and is served in the next IDLE evaluation.
  - It is never granted in the same cycle as the winner.
- prog_mode changes:
  - Sampled only in IDLE; an in-flight access always completes.
  - A CPU request pending when prog_mode rises waits, without a grant, until prog_mode=0.
- gnt and rvalid are never asserted for both requesters in the same cycle.
- mem_we=1 only in ACCESS and only for writes.

Optional Feature:
- Macro: ARB_CNT_EN.
- When defined:
  - Adds outputs cpu_cnt and ldr_cnt (8 bits each): saturating counts of grants per requester.
  - Each counter increments on its gnt pulse and holds at 255.
  - Both counters clear on reset.
  - Adds input cnt_clr, which clears both counters synchronously and takes precedence over an increment in the same cycle.
- When undefined: these ports and registers do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset, then CPU read of addr 3 with RAM[3]=0x2A, prog_mode=0 -> cpu_gnt at N+1 with mem_en=1, mem_we=0, mem_addr=3; cpu_rvalid at N+2 with cpu_rdata=0x2A; busy=1 for 2 cycles.
- Loader write of 0x1E to addr 15 with prog_mode=1, then CPU read of addr 15 after prog_mode=0 -> mem_we=1, mem_wdata=0x1E in ACCESS; the later read returns 0x1E.
- prog_mode=1 with cpu_req held 10 cycles -> no cpu_gnt and mem_en stays 0; drop prog_mode -> cpu_gnt 2 cycles later.
- LOADER_PRIO=0, both requesting continuously -> grants alternate LDR, CPU, LDR, CPU; LOADER_PRIO=1, same stimulus -> loader granted every time it requests.
- Assert rst during RDATA of a CPU read -> cpu_rvalid never pulses; all outputs 0; after release, a fresh request is served normally.
- ARB_CNT_EN defined: 300 CPU grants -> cpu_cnt=255; cnt_clr coincident with a grant -> cpu_cnt=0.
